// File: rtl/alu_pkg.sv
// Shared ALU control codes, controller state encoding and a code-validity helper
// used by the ALU and by the shared-ALU arbiter.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic alu_code_valid(input logic [3:0] ctrl);
      case (ctrl)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
         default:                                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; undefined control codes produce zero.
module alu
   import alu_pkg::*;
(
   input  logic [3:0]  alu_ctrl,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (alu_ctrl)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_SLT: result = {31'd0, (a < b)};
         ALU_NOR: result = ~(a | b);
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo NUM_REQ.
module alu_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_idx
);

   // Walk offsets from farthest to nearest so the nearest set request wins.
   always_comb begin
      int cand;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = int'(ptr) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant,
// operand capture, one-cycle execute, tagged response held until accepted.
module alu_share_arb
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [4*NUM_REQ-1:0]    req_ctrl,
   input  logic [32*NUM_REQ-1:0]   req_a,
   input  logic [32*NUM_REQ-1:0]   req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [31:0]             rsp_result,
   output logic                    rsp_zero,
   output logic                    rsp_err,
   output logic                    busy,
   output logic [15:0]             op_cnt
);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [3:0]        ctrl_q, ctrl_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [ID_W-1:0]   gid_q, gid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [31:0]       rsp_result_q, rsp_result_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic              rsp_err_q, rsp_err_d;
   logic [15:0]       op_cnt_q, op_cnt_d;

   logic [3:0]        ctrl_arr [NUM_REQ];
   logic [31:0]       a_arr    [NUM_REQ];
   logic [31:0]       b_arr    [NUM_REQ];

   logic              pick_valid;
   logic [ID_W-1:0]   pick_idx;
   logic              grant_en;
   logic              grant;
   logic [31:0]       alu_res;
   logic              code_ok;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign ctrl_arr[gi] = req_ctrl[4*gi +: 4];
      assign a_arr[gi]    = req_a[32*gi +: 32];
      assign b_arr[gi]    = req_b[32*gi +: 32];
   end

   alu_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req       (req_valid),
      .ptr       (ptr_q),
      .gnt_valid (pick_valid),
      .gnt_idx   (pick_idx)
   );

   alu u_alu (
      .alu_ctrl (ctrl_q),
      .a        (a_q),
      .b        (b_q),
      .result   (alu_res)
   );

   assign code_ok = alu_code_valid(ctrl_q);

   // Grants happen only from IDLE or on the response handshake; never while reset is held.
   assign grant_en = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
   assign grant    = grant_en && pick_valid;

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[pick_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      ctrl_d       = ctrl_q;
      a_d          = a_q;
      b_d          = b_q;
      gid_d        = gid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      op_cnt_d     = op_cnt_q;

      if (grant) begin
         ctrl_d = ctrl_arr[pick_idx];
         a_d    = a_arr[pick_idx];
         b_d    = b_arr[pick_idx];
         gid_d  = pick_idx;
         ptr_d  = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d      = ST_RESP;
            rsp_id_d     = gid_q;
            rsp_err_d    = !code_ok;
            rsp_result_d = code_ok ? alu_res : 32'd0;
            rsp_zero_d   = code_ok && (alu_res == 32'd0);
         end
         ST_RESP: begin
            if (rsp_ready) begin
               op_cnt_d = op_cnt_q + 16'd1;
               state_d  = grant ? ST_EXEC : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         ctrl_q       <= '0;
         a_q          <= '0;
         b_q          <= '0;
         gid_q        <= '0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         op_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         ctrl_q       <= ctrl_d;
         a_q          <= a_d;
         b_q          <= b_d;
         gid_q        <= gid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         op_cnt_q     <= op_cnt_d;
      end
   end

   assign rsp_valid  = (state_q == ST_RESP);
   assign busy       = (state_q != ST_IDLE);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign op_cnt     = op_cnt_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: cycle-level reference model plus directed table,
// hand-written corner sequences and randomized traffic.
module tb_alu_share_arb;

   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [4*N-1:0]  req_ctrl;
   logic [32*N-1:0] req_a;
   logic [32*N-1:0] req_b;
   logic            rsp_valid;
   logic            rsp_ready = 1'b1;
   logic [IW-1:0]   rsp_id;
   logic [31:0]     rsp_result;
   logic            rsp_zero;
   logic            rsp_err;
   logic            busy;
   logic [15:0]     op_cnt;

   always #5 clk = ~clk;

   alu_share_arb #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_ctrl   (req_ctrl),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .op_cnt     (op_cnt)
   );

   // Requester slots: a slot stays valid until the cycle after its grant.
   logic [N-1:0] slot_v = '0;
   logic [3:0]   slot_ctrl [N];
   logic [31:0]  slot_a    [N];
   logic [31:0]  slot_b    [N];
   logic [N-1:0] grant_seen = '0;
   logic         sticky = 1'b0;

   assign req_valid = slot_v;
   for (genvar gi = 0; gi < N; gi++) begin : g_drive
      assign req_ctrl[4*gi +: 4] = slot_ctrl[gi];
      assign req_a[32*gi +: 32]  = slot_a[gi];
      assign req_b[32*gi +: 32]  = slot_b[gi];
   end

   typedef struct {
      logic [IW-1:0] id;
      logic [31:0]   res;
      logic          zero;
      logic          err;
   } exp_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t ref_alu(input int id, input logic [3:0] c,
                                    input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.id  = IW'(id);
      e.err = 1'b0;
      case (c)
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b0010: e.res = a + b;
         4'b0110: e.res = a - b;
         4'b0111: e.res = (a < b) ? 32'd1 : 32'd0;
         4'b1100: e.res = ~(a | b);
         default: begin e.res = 32'd0; e.err = 1'b1; end
      endcase
      e.zero = !e.err && (e.res == 32'd0);
      return e;
   endfunction

   // Reference model state: 0 = nothing in flight, 1 = executing, 2 = response shown.
   int          m_stage = 0;
   int          m_ptr   = 0;
   logic [15:0] m_cnt   = '0;
   exp_t        m_exp;
   int          gnt_log[$];
   int          gnt_cyc[$];
   exp_t        last_rsp;
   int          rsp_count = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      int          g;
      logic        can;
      logic        hs;
      logic [N-1:0] er;
      if (!rst_n) begin
         m_stage = 0;
         m_ptr   = 0;
         m_cnt   = '0;
      end else begin
         chk("rsp_valid", 32'(rsp_valid), 32'(m_stage == 2));
         chk("busy", 32'(busy), 32'(m_stage != 0));
         chk("op_cnt", 32'(op_cnt), 32'(m_cnt));
         if (m_stage == 2) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_exp.id));
            chk("rsp_result", rsp_result, m_exp.res);
            chk("rsp_zero", 32'(rsp_zero), 32'(m_exp.zero));
            chk("rsp_err", 32'(rsp_err), 32'(m_exp.err));
         end
         can = (m_stage == 0) || (m_stage == 2 && rsp_ready);
         g = -1;
         if (can) begin
            for (int off = 0; off < N; off++) begin
               int idx;
               idx = (m_ptr + off) % N;
               if (g < 0 && req_valid[idx]) g = idx;
            end
         end
         er = '0;
         if (g >= 0) er[g] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(er));
         hs = (m_stage == 2) && rsp_ready;
         if (hs) begin
            m_cnt = m_cnt + 16'd1;
            last_rsp = m_exp;
            rsp_count++;
         end
         if (g >= 0) begin
            m_exp = ref_alu(g, slot_ctrl[g], slot_a[g], slot_b[g]);
            m_ptr = (g + 1) % N;
            grant_seen[g] = 1'b1;
            gnt_log.push_back(g);
            gnt_cyc.push_back(cyc);
         end
         if (m_stage == 1)       m_stage = 2;
         else if (hs)            m_stage = (g >= 0) ? 1 : 0;
         else if (m_stage == 0 && g >= 0) m_stage = 1;
      end
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (grant_seen[i]) begin
            if (!sticky) slot_v[i] = 1'b0;
            grant_seen[i] = 1'b0;
         end
      end
   end

   task automatic post(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (slot_v[i] && n < 100) begin @(posedge clk); #2; n++; end
      if (slot_v[i]) chk("post_timeout", 32'(slot_v[i]), 32'd0);
      slot_ctrl[i] = c; slot_a[i] = a; slot_b[i] = b; slot_v[i] = 1'b1;
   endtask

   task automatic wait_quiet(input int budget);
      int n = 0;
      while ((slot_v != '0 || m_stage != 0) && n < budget) begin @(posedge clk); #2; n++; end
      if (n >= budget) chk("quiet_timeout", 32'(n), 32'(budget - 1));
   endtask

   task automatic wait_stage(input int s, input int budget);
      int n = 0;
      while (m_stage != s && n < budget) begin @(posedge clk); #2; n++; end
      if (m_stage != s) chk("stage_timeout", 32'(m_stage), 32'(s));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
      chk({tag, "_rsp_result"}, rsp_result, 32'd0);
      chk({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_op_cnt"}, 32'(op_cnt), 32'd0);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst");
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   typedef struct {
      int          req;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        err;
   } vec_t;

   vec_t tbl [8];

   initial begin : main
      int base;
      int n;
      logic [3:0] codes [8];
      tbl[0] = '{0, 4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0};
      tbl[1] = '{2, 4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0};
      tbl[2] = '{2, 4'b0111, 32'h1,         32'h2,         32'h1,         1'b0, 1'b0};
      tbl[3] = '{3, 4'b1010, 32'h1234_5678, 32'h9,         32'h0,         1'b0, 1'b1};
      tbl[4] = '{1, 4'b0001, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0};
      tbl[5] = '{0, 4'b0000, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0,         1'b1, 1'b0};
      tbl[6] = '{1, 4'b0110, 32'h3,         32'h5,         32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[7] = '{3, 4'b1100, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 1'b0};
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010, 4'b1111};
      for (int i = 0; i < N; i++) begin slot_ctrl[i] = '0; slot_a[i] = '0; slot_b[i] = '0; end

      #2;
      chk_reset_outputs("por");
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;

      for (int t = 0; t < 8; t++) begin
         post(tbl[t].req, tbl[t].ctrl, tbl[t].a, tbl[t].b);
         wait_quiet(50);
         chk($sformatf("tbl%0d_id", t), 32'(last_rsp.id), 32'(tbl[t].req));
         chk($sformatf("tbl%0d_result", t), last_rsp.res, tbl[t].res);
         chk($sformatf("tbl%0d_zero", t), 32'(last_rsp.zero), 32'(tbl[t].zero));
         chk($sformatf("tbl%0d_err", t), 32'(last_rsp.err), 32'(tbl[t].err));
         if (t == 0) chk("first_op_cnt", 32'(op_cnt), 32'd1);
         $display("vector %0d: req%0d ctrl=%b a=%h b=%h -> result=%h zero=%b err=%b",
                  t, tbl[t].req, tbl[t].ctrl, tbl[t].a, tbl[t].b, last_rsp.res, last_rsp.zero, last_rsp.err);
      end

      // All requesters valid continuously: grants 0,1,2,3,0 two cycles apart.
      do_reset();
      base = gnt_log.size();
      sticky = 1'b1;
      for (int i = 0; i < N; i++) begin
         slot_ctrl[i] = 4'b0110; slot_a[i] = 32'd5; slot_b[i] = 32'd5;
      end
      slot_v = '1;
      n = 0;
      while (gnt_log.size() < base + 5 && n < 40) begin @(posedge clk); #2; n++; end
      sticky = 1'b0;
      chk("rr_grant_count", 32'(gnt_log.size() >= base + 5), 32'd1);
      if (gnt_log.size() >= base + 5) begin
         for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_order%0d", k), 32'(gnt_log[base + k]), 32'(k % N));
            if (k > 0) chk($sformatf("rr_spacing%0d", k), 32'(gnt_cyc[base + k] - gnt_cyc[base + k - 1]), 32'd2);
            $display("round-robin grant %0d -> requester %0d at cycle %0d", k, gnt_log[base + k], gnt_cyc[base + k]);
         end
      end
      wait_quiet(60);
      chk("rr_last_zero", 32'(last_rsp.zero), 32'd1);

      // Backpressure: response held 5 cycles while requester 1 waits.
      post(2, 4'b0010, 32'd10, 32'd20);
      rsp_ready = 1'b0;
      wait_stage(2, 20);
      post(1, 4'b1100, 32'd0, 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #2;
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_rsp_result", rsp_result, 32'd30);
      end
      base = gnt_log.size();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hs_grant", 32'(req_ready), 32'b0010);
      @(posedge clk); #2;
      wait_quiet(20);
      chk("bp_nor_result", last_rsp.res, 32'hFFFF_FFFF);
      chk("bp_nor_id", 32'(last_rsp.id), 32'd1);
      $display("backpressure: requester 1 NOR result %h after 5 held cycles", last_rsp.res);

      // Reset during EXEC of an AND: no response, pointer back to 0.
      post(3, 4'b0000, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
      wait_stage(1, 20);
      n = rsp_count;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      post(2, 4'b0010, 32'd1, 32'd1);
      post(0, 4'b0010, 32'd2, 32'd2);
      @(posedge clk); #2;
      chk("midrst_hold_ready", 32'(req_ready), 32'd0);
      base = gnt_log.size();
      rst_n = 1'b1;
      wait_quiet(40);
      chk("midrst_no_rsp", 32'(rsp_count), 32'(n + 2));
      chk("midrst_first_grant", 32'(gnt_log.size() > base ? gnt_log[base] : -1), 32'd0);
      $display("mid-EXEC reset: first grant after release -> requester %0d", gnt_log[base]);

      // Randomized traffic with payload churn and random backpressure.
      n = rsp_count;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #2;
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!slot_v[i] && $urandom_range(0, 9) < 3) begin
               slot_ctrl[i] = codes[$urandom_range(0, 7)];
               slot_a[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
               slot_b[i] = ($urandom_range(0, 3) == 0) ? slot_a[i] : $urandom;
               slot_v[i] = 1'b1;
            end else if (slot_v[i] && $urandom_range(0, 9) == 0) begin
               slot_a[i] = $urandom;
            end
         end
      end
      rsp_ready = 1'b1;
      wait_quiet(100);
      $display("random phase: %0d responses", rsp_count - n);
      chk("random_progress", 32'(rsp_count - n > 100), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
